// File: rtl/r_cpu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type CPU: owns PC and IR, decodes funct to alu_op.
// Latency: a legal instruction takes 4 clka from FETCH to WB; an unsupported one takes 2 clka.
// Backpressure: run is sampled only in FETCH; an instruction in flight always completes, then parks in FETCH.
module r_cpu_ctrl #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              run,
    input  logic [31:0]       inst,
    input  logic              alu_of,
    input  logic              alu_zf,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic [2:0]        alu_op,
    output logic              rf_we,
    output logic              ofa,
    output logic              zfa,
    output logic              busy,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_WB     = 2'b11
    } state_t;

    // R-type funct codes supported by the ALU
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   pc_q,      pc_d;
    logic [31:0]         ir_q,      ir_d;
    logic [2:0]          alu_op_q,  alu_op_d;
    logic                rf_we_q,   rf_we_d;
    logic                ofa_q,     ofa_d;
    logic                zfa_q,     zfa_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic                dec_legal;
    logic [2:0]          dec_op;

    // Opcode and shamt bits of the IR are only checked at DECODE time on the ROM data
    logic                unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[31:26], ir_q[10:0]};

    // Decode the ROM word presented during DECODE into legality and ALU operation
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 3'b000;
        if (inst[31:26] == 6'd0) begin
            unique case (inst[5:0])
                FN_ADD:  begin dec_legal = 1'b1; dec_op = 3'b000; end
                FN_SUB:  begin dec_legal = 1'b1; dec_op = 3'b001; end
                FN_AND:  begin dec_legal = 1'b1; dec_op = 3'b010; end
                FN_OR:   begin dec_legal = 1'b1; dec_op = 3'b011; end
                FN_XOR:  begin dec_legal = 1'b1; dec_op = 3'b100; end
                FN_NOR:  begin dec_legal = 1'b1; dec_op = 3'b101; end
                FN_SLT:  begin dec_legal = 1'b1; dec_op = 3'b110; end
                default: begin dec_legal = 1'b0; dec_op = 3'b000; end
            endcase
        end
    end

    // Next-state and registered-output logic for the four-state sequencer
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        rf_we_d   = 1'b0;
        ofa_d     = ofa_q;
        zfa_d     = zfa_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_FETCH: begin
                alu_op_d = 3'b000;
                if (run) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ir_d = inst;
                if (dec_legal) begin
                    // alu_op is loaded here so it is already valid on the first EXEC cycle
                    alu_op_d = dec_op;
                    state_d  = ST_EXEC;
                end else begin
                    // Skip the bad word: no write, no flag update, not counted as retired
                    illegal_d = 1'b1;
                    pc_d      = pc_q + PC_ONE;
                    state_d   = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // Writes to r0 are suppressed; the WB cycle still runs to latch the flags
                rf_we_d = (ir_q[15:11] != 5'd0);
                state_d = ST_WB;
            end
            ST_WB: begin
                ofa_d     = alu_of;
                zfa_d     = alu_zf;
                pc_d      = pc_q + PC_ONE;
                retired_d = retired_q + CNT_ONE;
                alu_op_d  = 3'b000;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register; reset wins over any in-flight instruction
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            alu_op_q  <= 3'b000;
            rf_we_q   <= 1'b0;
            ofa_q     <= 1'b0;
            zfa_q     <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            rf_we_q   <= rf_we_d;
            ofa_q     <= ofa_d;
            zfa_q     <= zfa_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign inst_addr = pc_q;
    assign rs_addr   = ir_q[25:21];
    assign rt_addr   = ir_q[20:16];
    assign rd_addr   = ir_q[15:11];
    assign alu_op    = alu_op_q;
    assign rf_we     = rf_we_q;
    assign ofa       = ofa_q;
    assign zfa       = zfa_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign busy      = (state_q != ST_FETCH);

endmodule

// File: doc/r_cpu_ctrl.md
Name: r_cpu_ctrl

Overview:
- Multi-cycle control sequencer for the R-type CPU datapath (instruction ROM, register file, ALU).
- Owns the PC and instruction register, and decodes R-type instructions into register-file addresses and ALU operation codes.
- Issues one register-file write per instruction and latches the ALU flags that drive the top-level ofa/zfa outputs.
- Sits between the instruction ROM and the register file/ALU inside the R_CPU top level.

Parameters:
- ADDR_W, 6, instruction ROM word-address width; PC wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clka  in  1  system clock; all state updates on the rising edge.
- rsta  in  1  synchronous reset, active-high.
- run  in  1  sequencing enable; sampled only in FETCH.
- inst  in  32  instruction ROM read data; registered ROM, valid 1 cycle after inst_addr.
- alu_of  in  1  ALU overflow flag for the current operands.
- alu_zf  in  1  ALU zero flag for the current operands.
- inst_addr  out  ADDR_W  ROM word address, equal to the PC.
- rs_addr  out  5  register-file read port A address, IR[25:21].
- rt_addr  out  5  register-file read port B address, IR[20:16].
- rd_addr  out  5  register-file write address, IR[15:11].
- alu_op  out  3  ALU operation select.
- rf_we  out  1  register-file write enable, single-cycle pulse.
- ofa  out  1  latched overflow flag.
- zfa  out  1  latched zero flag.
- busy  out  1  high in every state except FETCH.
- illegal  out  1  sticky unsupported-instruction flag.
- retired  out  CNT_W  count of completed legal instructions; wraps.

Behaviour:
- Reset (rsta=1 at an edge): state=FETCH, PC=0, IR=0, ofa=0, zfa=0, illegal=0, retired=0, rf_we=0, alu_op=000.
  - Reset has priority over every other event, including reset in the middle of an instruction.
- States and transitions, 2-bit encoding:
  - FETCH(00): inst_addr=PC. If run=1, go to DECODE; otherwise stay in FETCH.
  - DECODE(01): IR<=inst.
    - Legal iff inst[31:26]==0 and funct inst[5:0] is in the table below.
    - Legal: go to EXEC.
    - Illegal: set illegal=1, PC<=PC+1, go to FETCH. No write, no flag update, retired unchanged.
  - EXEC(10): alu_op driven from the IR funct field; rs/rt/rd addresses are stable from the IR. Go to WB unconditionally.
  - WB(11):
    - rf_we=1 for exactly this cycle, unless rd_addr==0, in which case rf_we=0.
    - ofa<=alu_of and zfa<=alu_zf, including when rd==0.
    - PC<=PC+1 (wraps to 0 from 2^ADDR_W-1); retired<=retired+1 (wraps); go to FETCH.
- Funct-to-alu_op table:
  - 0x20 add -> 000
  - 0x22 sub -> 001
  - 0x24 and -> 010
  - 0x25 or -> 011
  - 0x26 xor -> 100
  - 0x27 nor -> 101
  - 0x2A slt -> 110
  - any other funct -> illegal
- Output timing:
  - alu_op is held from EXEC through WB and is 000 in FETCH/DECODE.
  - rs/rt/rd are combinational from the IR.
- Latency: a legal instruction takes 4 cycles FETCH->WB. The throughput is 1 instruction per 4 clka with run held high. An illegal instruction costs 2 cycles.
- run deasserted mid-instruction: the current instruction completes; the controller then parks in FETCH with PC already advanced.
- illegal is cleared only by rsta.

Test Plan:
- Reset with run=0 for 5 cycles -> state FETCH, inst_addr=0, busy=0, rf_we=0, ofa=zfa=0, retired=0.
- run=1, ROM[0]=0x00430820 (add rd=1, rs=2, rt=3), alu_of=0, alu_zf=0 -> rf_we pulses in cycle 4 with rd_addr=1, alu_op=000, retired=1, inst_addr=1.
- ROM[1]=0x00000822 (sub rd=1, rs=0, rt=0), alu_zf=1 in WB -> zfa=1 after WB. Then ROM[2]=0x00010020 (add rd=0), alu_of=1 -> rf_we stays 0, ofa=1, retired increments.
- ROM[k]=0x8C000000 (nonzero opcode) -> illegal=1 after DECODE, no rf_we, retired unchanged, PC=k+1 after 2 cycles. Also apply funct 0x3F -> same response.
- ADDR_W=6, PC=63, legal instruction -> after WB inst_addr=0. Also start retired at 0xFFFF -> after the next legal instruction retired=0.
- Assert rsta during EXEC of an add -> no rf_we pulse, PC=0, all outputs at reset values the next cycle. Separately, drop run during DECODE -> the instruction completes, then busy=0 and inst_addr is held.
